// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared types and constants for the instruction-memory boot loader.
//   IMEM_AW    : default instruction-memory word-address width (64 words)
//   WORD_BYTES : bytes per instruction word
//   word_t     : one 32-bit instruction word
//   state_e    : loader FSM states
package imem_pkg;

   localparam int unsigned IMEM_AW    = 6;
   localparam int unsigned WORD_BYTES = 4;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StWrite,
      StDone
   } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer
//   Assembles a little-endian byte stream into 32-bit words. Each accepted byte is
//   shifted in from the top, so after four bytes the first one sits in bits 7:0.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : restart at lane 0 (new load)
//     take       : a byte is transferred this cycle
//     data       : byte being transferred
//     word_full  : this transfer completes a word (combinational)
//     word       : assembled word, valid the cycle after word_full
module imem_byte_packer
   import imem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       take,
   input  logic [7:0] data,
   output logic       word_full,
   output word_t      word
);

   logic [1:0] byte_cnt_q;
   word_t      word_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         word_q     <= '0;
      end else if (clear) begin
         byte_cnt_q <= '0;
      end else if (take) begin
         byte_cnt_q <= byte_cnt_q + 2'd1;
         word_q     <= {data, word_q[31:8]};
      end
   end

   assign word_full = take && (byte_cnt_q == 2'(WORD_BYTES - 1));
   assign word      = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a program image from a byte stream into the instruction memory and
//   holds the core (cpu_run=0) until the whole image has been written.
//   Optional build macro IMEM_LOAD_CHECKSUM_EN: a trailing 4-byte checksum word
//   (mod 2^32 sum of the data words) must match before the core is released.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     ld_start          : pulse, begins a load of ld_nwords words
//     ld_nwords         : image length in words, captured on ld_start
//     ld_valid/ld_byte  : byte source; ld_ready is the loader's acceptance
//     mem_we/mem_waddr/mem_wdata : instruction-memory write port
//     cpu_run           : core released to fetch
//     busy              : load in progress
//     done / err        : sticky load status, cleared by the next ld_start
module imem_boot_loader
   import imem_pkg::*;
#(
   parameter int unsigned AW        = IMEM_AW,
   parameter int unsigned BASE_WORD = 0,
   parameter int unsigned MAX_WORDS = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_start,
   input  logic [AW:0]   ld_nwords,
   input  logic          ld_valid,
   input  logic [7:0]    ld_byte,
   output logic          ld_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output word_t         mem_wdata,
   output logic          cpu_run,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned MemWords = 1 << AW;

   state_e      state_q, state_d;
   logic [AW:0] nwords_q, nwords_d;
   logic [AW:0] word_cnt_q, word_cnt_d;
   logic [AW:0] word_cnt_inc;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] nw_ext;
   logic        len_ok;
   logic        pk_clear;
   logic        word_full;
   word_t       word;

`ifdef IMEM_LOAD_CHECKSUM_EN
   word_t sum_q, sum_d;
   logic  chk_q, chk_d;  // receiving the checksum word rather than data
`endif

   // Length check up front guarantees the write address never wraps.
   assign nw_ext = 32'(ld_nwords);
   assign len_ok = (nw_ext != 32'd0) && (nw_ext <= MAX_WORDS) &&
                   ((BASE_WORD + nw_ext) <= MemWords);

   assign word_cnt_inc = word_cnt_q + 1'b1;
   assign pk_clear     = (state_q == StIdle) && ld_start;

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pk_clear),
      .take      (ld_valid && ld_ready),
      .data      (ld_byte),
      .word_full (word_full),
      .word      (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         nwords_q   <= '0;
         word_cnt_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         nwords_q   <= nwords_d;
         word_cnt_q <= word_cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

`ifdef IMEM_LOAD_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         chk_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         chk_q <= chk_d;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      nwords_d   = nwords_q;
      word_cnt_d = word_cnt_q;
      done_d     = done_q;
      err_d      = err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_d      = sum_q;
      chk_d      = chk_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (ld_start) begin
               done_d = 1'b0;
               if (len_ok) begin
                  err_d      = 1'b0;
                  nwords_d   = ld_nwords;
                  word_cnt_d = '0;
                  state_d    = StRecv;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  sum_d      = '0;
                  chk_d      = 1'b0;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRecv: begin
            if (word_full) state_d = StWrite;
         end
         StWrite: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (chk_q) begin
               // Checksum word: compare only, nothing is written.
               if (word == sum_q) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end else begin
               word_cnt_d = word_cnt_inc;
               sum_d      = sum_q + word;
               if (word_cnt_inc == nwords_q) chk_d = 1'b1;
               state_d    = StRecv;
            end
`else
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == nwords_q) begin
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               state_d = StRecv;
            end
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef IMEM_LOAD_CHECKSUM_EN
   assign mem_we = (state_q == StWrite) && !chk_q;
`else
   assign mem_we = (state_q == StWrite);
`endif

   assign ld_ready  = (state_q == StRecv);
   assign busy      = (state_q == StRecv) || (state_q == StWrite);
   assign mem_waddr = mem_we ? (AW'(BASE_WORD) + word_cnt_q[AW-1:0]) : '0;
   assign mem_wdata = mem_we ? word : '0;
   // done is cleared on every start, so a partial or failed image never runs.
   assign cpu_run   = done_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Directed bench for imem_boot_loader: inputs are driven and outputs sampled on
//   the falling clock edge; the write monitor counts mem_we on the rising edge.
module tb_imem_boot_loader;

   logic        clk;
   logic        rst_n;
   logic        ld_start;
   logic [6:0]  ld_nwords;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_ready;
   logic        mem_we;
   logic [5:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        cpu_run;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;
   int we_count = 0;
   logic [31:0] last_data = '0;

   imem_boot_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_start  (ld_start),
      .ld_nwords (ld_nwords),
      .ld_valid  (ld_valid),
      .ld_byte   (ld_byte),
      .ld_ready  (ld_ready),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .cpu_run   (cpu_run),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         we_count  <= we_count + 1;
         last_data <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [6:0] n);
      ld_start  = 1'b1;
      ld_nwords = n;
      @(negedge clk);
      ld_start  = 1'b0;
   endtask

   // Present one byte and hold it until the loader is ready for it.
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok       = 1'b0;
      ld_valid = 1'b1;
      ld_byte  = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (ld_ready) ok = 1'b1;
         @(negedge clk);
      end
      check("byte_accept", 32'(ok), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   // Called in the cycle of the last data write; returns in the DONE cycle.
   task automatic finish_load(input logic [31:0] sum);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_word(sum);
      ld_valid = 1'b0;
      check("chk_no_we", 32'(mem_we), 32'd0);
      @(negedge clk);
`else
      check("last_we_busy", 32'(busy), 32'd1);
      @(negedge clk);
`endif
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {26'd0, ld_ready, mem_we, cpu_run, busy, done, err}, 32'd0);
      check({tag, "_addr"}, 32'(mem_waddr), 32'd0);
      check({tag, "_data"}, mem_wdata, 32'd0);
   endtask

   initial begin
      logic [7:0] t2_bytes [4];
      t2_bytes = '{8'h33, 8'hE2, 8'h62, 8'h00};
      rst_n     = 1'b0;
      ld_start  = 1'b0;
      ld_nwords = '0;
      ld_valid  = 1'b0;
      ld_byte   = '0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: two-word load streamed back to back
      start(7'd2);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_ready", 32'(ld_ready), 32'd1);
      send_byte(8'h03);
      send_byte(8'hA3);
      send_byte(8'hC4);
      send_byte(8'hFF);
      check("t1_we0", 32'(mem_we), 32'd1);
      check("t1_addr0", 32'(mem_waddr), 32'd0);
      check("t1_data0", mem_wdata, 32'hFFC4A303);
      check("t1_ready_in_write", 32'(ld_ready), 32'd0);
      send_byte(8'h23);
      send_byte(8'hA4);
      send_byte(8'h64);
      send_byte(8'h00);
      ld_valid = 1'b0;
      check("t1_we1", 32'(mem_we), 32'd1);
      check("t1_addr1", 32'(mem_waddr), 32'd1);
      check("t1_data1", mem_wdata, 32'h0064A423);
      check("t1_run_at_we", 32'(cpu_run), 32'd0);
      finish_load(32'h00294726);
      check("t1_run", 32'(cpu_run), 32'd1);
      check("t1_done", 32'(done), 32'd1);
      check("t1_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("t1_run_sticky", 32'(cpu_run), 32'd1);
      check("t1_we_count", 32'(we_count), 32'd2);

      // 2: valid toggling every cycle, one-word load
      start(7'd1);
      check("t2_done_cleared", 32'(done), 32'd0);
      check("t2_run_dropped", 32'(cpu_run), 32'd0);
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1'b1;
         ld_byte  = t2_bytes[k];
         @(negedge clk);
         ld_valid = 1'b0;
         ld_byte  = 8'hAA;
         if (k < 3) begin
            check("t2_gap_ready", 32'(ld_ready), 32'd1);
            @(negedge clk);
         end
      end
      check("t2_we", 32'(mem_we), 32'd1);
      check("t2_addr", 32'(mem_waddr), 32'd0);
      check("t2_data", mem_wdata, 32'h0062E233);
      finish_load(32'h0062E233);
      check("t2_done", 32'(done), 32'd1);
      check("t2_we_count", 32'(we_count), 32'd3);
      check("t2_last_data", last_data, 32'h0062E233);
      @(negedge clk);

      // 3a: zero length rejected; valid in IDLE consumes nothing
      ld_valid = 1'b1;
      ld_byte  = 8'h55;
      start(7'd0);
      check("t3_err0", 32'(err), 32'd1);
      check("t3_done0", 32'(done), 32'd0);
      check("t3_run0", 32'(cpu_run), 32'd0);
      check("t3_ready0", 32'(ld_ready), 32'd0);
      @(negedge clk);
      check("t3_busy0", 32'(busy), 32'd0);
      ld_valid = 1'b0;

      // 4: reset two bytes into a one-word load
      start(7'd1);
      check("t4_err_cleared", 32'(err), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
      send_byte(8'hE3);
      send_byte(8'h0A);
      ld_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("t4_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t4_no_we", 32'(we_count), 32'd3);

      // 3b: 65 words exceeds the memory
      start(7'd65);
      check("t3_err65", 32'(err), 32'd1);
      check("t3_ready65", 32'(ld_ready), 32'd0);
      check("t3_busy65", 32'(busy), 32'd0);
      check("t3_run65", 32'(cpu_run), 32'd0);

      // 64 words is the largest legal image
      start(7'd64);
      check("max_len_busy", 32'(busy), 32'd1);
      check("max_len_err", 32'(err), 32'd0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 4 (cont.): fresh load after reset
      start(7'd1);
      send_word(32'hFE420AE3);
      ld_valid = 1'b0;
      check("t4_we", 32'(mem_we), 32'd1);
      check("t4_addr", 32'(mem_waddr), 32'd0);
      check("t4_data", mem_wdata, 32'hFE420AE3);
      finish_load(32'hFE420AE3);
      check("t4_done", 32'(done), 32'd1);
      check("t4_run", 32'(cpu_run), 32'd1);
      @(negedge clk);

      // 5: ld_start pulses during RECV are ignored
      start(7'd2);
      send_word(32'h44332211);
      ld_valid = 1'b0;
      check("t5_addr0", 32'(mem_waddr), 32'd0);
      @(negedge clk);
      start(7'd1);
      check("t5_busy", 32'(busy), 32'd1);
      send_byte(8'h55);
      send_byte(8'h66);
      ld_valid = 1'b0;
      start(7'd1);
      send_byte(8'h77);
      send_byte(8'h88);
      ld_valid = 1'b0;
      check("t5_we1", 32'(mem_we), 32'd1);
      check("t5_addr1", 32'(mem_waddr), 32'd1);
      check("t5_data1", mem_wdata, 32'h88776655);
      finish_load(32'hCCAA8866);
      check("t5_done", 32'(done), 32'd1);
      check("t5_run", 32'(cpu_run), 32'd1);
      @(negedge clk);

`ifdef IMEM_LOAD_CHECKSUM_EN
      // 6: checksum good, then bad
      start(7'd2);
      send_word(32'h00000001);
      send_word(32'h00000002);
      send_word(32'h00000003);
      ld_valid = 1'b0;
      check("t6_good_no_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      check("t6_good_done", 32'(done), 32'd1);
      check("t6_good_run", 32'(cpu_run), 32'd1);
      @(negedge clk);
      start(7'd2);
      send_word(32'h00000001);
      send_word(32'h00000002);
      send_word(32'h00000004);
      ld_valid = 1'b0;
      @(negedge clk);
      check("t6_bad_err", 32'(err), 32'd1);
      check("t6_bad_done", 32'(done), 32'd0);
      check("t6_bad_run", 32'(cpu_run), 32'd0);
      check("t6_bad_busy", 32'(busy), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
